// File: rtl/lvds_train_pkg.sv
// Purpose: shared state encoding, protocol bytes and pattern helpers for the LVDS trainer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lvds_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_START = 4'd2,
    ST_WAIT  = 4'd3,
    ST_STEP1 = 4'd4,
    ST_STEP2 = 4'd5,
    ST_STEP3 = 4'd6,
    ST_END   = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERROR = 4'd9
  } state_e;

  // Bytes the master sends.
  localparam logic [7:0] TX_START = 8'h54;
  localparam logic [7:0] TX_REP1  = 8'h55;
  localparam logic [7:0] TX_REP2  = 8'h56;
  localparam logic [7:0] TX_REP3  = 8'h57;

  // Acks the slave returns.
  localparam logic [7:0] RX_ACK0 = 8'h58;
  localparam logic [7:0] RX_ACK1 = 8'h59;
  localparam logic [7:0] RX_ACK2 = 8'h5A;
  localparam logic [7:0] RX_ACK3 = 8'h5B;

  localparam logic [7:0] PAT_STEP1 = 8'h55;
  localparam logic [7:0] PAT_STEP2 = 8'h82;
  localparam logic [7:0] PAT_ROT0  = 8'h55;
  localparam logic [7:0] PAT_ROT1  = 8'hAA;
  localparam logic [7:0] PAT_ROT2  = 8'h99;
  localparam logic [7:0] PAT_ROT3  = 8'h66;

  // Ack byte that advances the given state; 0 means the state takes no ack.
  function automatic logic [7:0] ack_code(state_e st);
    case (st)
      ST_WAIT:  ack_code = RX_ACK0;
      ST_STEP1: ack_code = RX_ACK1;
      ST_STEP2: ack_code = RX_ACK2;
      ST_STEP3: ack_code = RX_ACK3;
      default:  ack_code = 8'h00;
    endcase
  endfunction

  // State reached when the expected ack arrives.
  function automatic state_e ack_next(state_e st);
    case (st)
      ST_WAIT:  ack_next = ST_STEP1;
      ST_STEP1: ack_next = ST_STEP2;
      ST_STEP2: ack_next = ST_STEP3;
      ST_STEP3: ack_next = ST_END;
      default:  ack_next = ST_IDLE;
    endcase
  endfunction

  // Byte queued when a state is entered; 0 means nothing is sent.
  function automatic logic [7:0] entry_tx(state_e st);
    case (st)
      ST_START: entry_tx = TX_START;
      ST_STEP1: entry_tx = TX_REP1;
      ST_STEP2: entry_tx = TX_REP2;
      ST_STEP3: entry_tx = TX_REP3;
      default:  entry_tx = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] pat_rot(logic [1:0] idx);
    case (idx)
      2'd0:    pat_rot = PAT_ROT0;
      2'd1:    pat_rot = PAT_ROT1;
      2'd2:    pat_rot = PAT_ROT2;
      default: pat_rot = PAT_ROT3;
    endcase
  endfunction

endpackage

// File: rtl/lvds_train_tick.sv
// Purpose: base-tick prescaler plus long-period counter for the LVDS trainer.
// Latency: tick_o every P_TICK+1 cycles while running; period_o on every P_PERIOD_TICKS-th tick.
// Backpressure: none; free-running while run_i=1.
// Ports: clk_i/rst_i (sync, active-high); run_i=0 holds both counters at their load values;
//        reload_i reloads the period counter only; tick_o/period_o are single-cycle strobes.
module lvds_train_tick #(
  parameter logic [19:0] P_TICK         = 20'hF4240,
  parameter int unsigned P_PERIOD_TICKS = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic reload_i,
  output logic tick_o,
  output logic period_o
);

  localparam logic [15:0] PER_LOAD = 16'(P_PERIOD_TICKS);

  logic [19:0] tick_q;
  logic [15:0] per_q;

  assign tick_o   = run_i && (tick_q == 20'd0);
  // Boundary is the tick that would take the counter from 1 to 0.
  assign period_o = tick_o && (per_q == 16'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      tick_q <= P_TICK;
      per_q  <= PER_LOAD;
    end else begin
      tick_q <= tick_o ? P_TICK : tick_q - 20'd1;
      if (reload_i) begin
        per_q <= PER_LOAD;
      end else if (tick_o) begin
        per_q <= (per_q == 16'd1) ? PER_LOAD : per_q - 16'd1;
      end
    end
  end

endmodule

// File: rtl/lvds_train_master.sv
// Purpose: LVDS link-training master: START/STEP1-3 handshake over UART bytes, training patterns out.
// Latency: reply byte 2 cycles after its ack at the earliest; TRAIN_DAT lags TRAIN_STATE by 1 cycle.
// Backpressure: one-entry TX holding register drains only while tx_rdy_i=1; newer request overwrites.
// Ports: clk_i, rst_i (sync, active-high); tx_rdy_i/tx_en_o/tx_dat_o UART TX; rx_en_i/rx_dat_i UART RX;
//        retrain_i restart from DONE/ERROR; train_dat_o pattern; train_done_o/train_err_o sticky flags;
//        train_state_o FSM encoding; retry_cnt_o step timeouts since IDLE.
module lvds_train_master
  import lvds_train_pkg::*;
#(
  parameter logic [19:0] P_TICK         = 20'hF4240,
  parameter int unsigned P_PERIOD_TICKS = 40,
  parameter int unsigned P_ACK_TICKS    = 40,
  parameter int unsigned P_RETRY_MAX    = 8,
  parameter int unsigned P_PAT_NUM      = 4,
  parameter int unsigned C_DATA_WIDTH   = 59
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tx_rdy_i,
  output logic                      tx_en_o,
  output logic [7:0]                tx_dat_o,
  input  logic                      rx_en_i,
  input  logic [7:0]                rx_dat_i,
  input  logic                      retrain_i,
  output logic [8*C_DATA_WIDTH-1:0] train_dat_o,
  output logic                      train_done_o,
  output logic                      train_err_o,
  output logic [3:0]                train_state_o,
  output logic [7:0]                retry_cnt_o
);

  localparam logic [15:0] ACK_LOAD  = 16'(P_ACK_TICKS);
  localparam logic [7:0]  RETRY_MAX = 8'(P_RETRY_MAX);
  localparam logic [1:0]  PAT_LAST  = 2'(P_PAT_NUM - 1);

  state_e                    state_q;
  logic [7:0]                retry_q;
  logic [15:0]               ack_q;
  logic                      tx_req_q;
  logic [7:0]                tx_req_dat_q;
  logic                      pend_q;
  logic [7:0]                hold_q;
  logic [1:0]                pat_idx_q;
  logic [8*C_DATA_WIDTH-1:0] train_dat_q;
  logic                      done_q;
  logic                      err_q;

  logic tick;
  logic period_end;
  logic ack_hit;
  logic step_timeout;

  lvds_train_tick #(
    .P_TICK         (P_TICK),
    .P_PERIOD_TICKS (P_PERIOD_TICKS)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q != ST_IDLE),
    .reload_i (state_q == ST_STEP3),
    .tick_o   (tick),
    .period_o (period_end)
  );

  assign ack_hit      = rx_en_i && (ack_code(state_q) != 8'h00) && (rx_dat_i == ack_code(state_q));
  assign step_timeout = tick && (ack_q == 16'd1);

  // Drain is combinational on tx_rdy_i so a byte leaves in the same cycle the UART offers space.
  assign tx_en_o  = pend_q && tx_rdy_i;
  assign tx_dat_o = tx_en_o ? hold_q : 8'h00;

  assign train_dat_o   = train_dat_q;
  assign train_done_o  = done_q;
  assign train_err_o   = err_q;
  assign train_state_o = state_q;
  assign retry_cnt_o   = retry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      retry_q      <= 8'd0;
      ack_q        <= ACK_LOAD;
      tx_req_q     <= 1'b0;
      tx_req_dat_q <= 8'h00;
      pend_q       <= 1'b0;
      hold_q       <= 8'h00;
      pat_idx_q    <= 2'd0;
      train_dat_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tx_req_q <= 1'b0;
      if (tick && ack_q != 16'd0) begin
        ack_q <= ack_q - 16'd1;
      end

      // Transitions raise tx_req_q; the byte is queued a cycle later so it is
      // issued from the state it belongs to.
      case (state_q)
        ST_IDLE: begin
          retry_q <= 8'd0;
          state_q <= ST_INIT;
        end
        ST_INIT: begin
          if (period_end) begin
            state_q      <= ST_START;
            tx_req_q     <= 1'b1;
            tx_req_dat_q <= TX_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT, ST_STEP1, ST_STEP2, ST_STEP3: begin
          // Ack has priority over both the WAIT resend and a step timeout.
          if (ack_hit) begin
            state_q      <= ack_next(state_q);
            tx_req_q     <= (entry_tx(ack_next(state_q)) != 8'h00);
            tx_req_dat_q <= entry_tx(ack_next(state_q));
            ack_q        <= ACK_LOAD;
          end else if (state_q == ST_WAIT) begin
            if (period_end) begin
              state_q      <= ST_START;
              tx_req_q     <= 1'b1;
              tx_req_dat_q <= TX_START;
            end
          end else if (step_timeout) begin
            if (retry_q < RETRY_MAX) begin
              retry_q      <= retry_q + 8'd1;
              state_q      <= ST_START;
              tx_req_q     <= 1'b1;
              tx_req_dat_q <= TX_START;
            end else begin
              state_q <= ST_ERROR;
            end
          end
        end
        ST_END: begin
          if (period_end) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (retrain_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A request arriving with a drain keeps the new byte pending.
      if (tx_req_q) begin
        pend_q <= 1'b1;
        hold_q <= tx_req_dat_q;
      end else if (tx_en_o) begin
        pend_q <= 1'b0;
      end

      // Flags drop in the same edge that accepts RETRAIN.
      done_q <= (state_q == ST_DONE) && !retrain_i;
      err_q  <= (state_q == ST_ERROR) && !retrain_i;

      case (state_q)
        ST_STEP1: train_dat_q <= {C_DATA_WIDTH{PAT_STEP1}};
        ST_STEP2: train_dat_q <= {C_DATA_WIDTH{PAT_STEP2}};
        ST_STEP3: train_dat_q <= {C_DATA_WIDTH{pat_rot(pat_idx_q)}};
        default:  train_dat_q <= '0;
      endcase
      // Index is 0 on the first STEP3 cycle and wraps after PAT_LAST.
      if (state_q != ST_STEP3 || pat_idx_q == PAT_LAST) begin
        pat_idx_q <= 2'd0;
      end else begin
        pat_idx_q <= pat_idx_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lvds_train_master.sv
// Purpose: directed, table-driven check of the LVDS training master with short timing parameters.
// Latency: n/a (testbench).
// Backpressure: exercises TX_RDY low while a byte is pending.
module tb_lvds_train_master;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_rdy = 1'b0;
  logic          rx_en = 1'b0;
  logic [7:0]    rx_dat = 8'h00;
  logic          retrain = 1'b0;
  logic          tx_en;
  logic [7:0]    tx_dat;
  logic [8*DW-1:0] train_dat;
  logic          train_done;
  logic          train_err;
  logic [3:0]    train_state;
  logic [7:0]    retry_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] ack;
    logic [3:0] st;
    logic [7:0] pat;
    logic [7:0] tx;
  } vec_t;

  vec_t vecs[3];

  lvds_train_master #(
    .P_TICK         (20'd9),
    .P_PERIOD_TICKS (4),
    .P_ACK_TICKS    (3),
    .P_RETRY_MAX    (2),
    .P_PAT_NUM      (3),
    .C_DATA_WIDTH   (DW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_rdy_i      (tx_rdy),
    .tx_en_o       (tx_en),
    .tx_dat_o      (tx_dat),
    .rx_en_i       (rx_en),
    .rx_dat_i      (rx_dat),
    .retrain_i     (retrain),
    .train_dat_o   (train_dat),
    .train_done_o  (train_done),
    .train_err_o   (train_err),
    .train_state_o (train_state),
    .retry_cnt_o   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8*DW-1:0] rep(input logic [7:0] b);
    rep = {DW{b}};
  endfunction

  task automatic send(input logic [7:0] b);
    rx_en = 1'b1;
    rx_dat = b;
    step();
    rx_en = 1'b0;
    rx_dat = 8'h00;
  endtask

  task automatic wait_tx(input int maxc, output int n);
    n = 0;
    while (tx_en !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    bit bad;

    vecs[0] = '{ack: 8'h58, st: 4'd4, pat: 8'h55, tx: 8'h56 - 8'h01};
    vecs[1] = '{ack: 8'h59, st: 4'd5, pat: 8'h82, tx: 8'h56};
    vecs[2] = '{ack: 8'h5A, st: 4'd6, pat: 8'h55, tx: 8'h57};

    // Reset values, with TX_RDY high so a stray pending byte would show.
    rst = 1'b1;
    tx_rdy = 1'b1;
    repeat (3) step();
    chk("rst_state", train_state, 4'd0);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tx_dat", tx_dat, 8'h00);
    chk("rst_train_dat", train_dat, '0);
    chk("rst_done", train_done, 1'b0);
    chk("rst_err", train_err, 1'b0);
    chk("rst_retry", retry_cnt, 8'd0);

    // Release; cycle 0 is IDLE, INIT next, START at 41, 0x54 pending from 42.
    tx_rdy = 1'b0;
    rst = 1'b0;
    cyc = 0;
    step();
    chk("init_state", train_state, 4'd1);
    bad = 1'b0;
    while (cyc < 61) begin
      step();
      if (cyc == 41) chk("start_state", train_state, 4'd2);
      if (tx_en !== 1'b0) bad = 1'b1;
    end
    chk("no_tx_while_not_rdy", bad, 1'b0);
    chk("wait_state_pending", train_state, 4'd3);
    tx_rdy = 1'b1;
    #1;
    chk("tx_start_on_rdy", tx_en, 1'b1);
    chk("tx_start_dat", tx_dat, 8'h54);

    // Table: ack -> state next cycle, pattern and reply byte two cycles after the ack.
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].ack);
      chk($sformatf("vec%0d_state", i), train_state, vecs[i].st);
      chk($sformatf("vec%0d_tx_quiet", i), tx_en, 1'b0);
      step();
      chk($sformatf("vec%0d_pat", i), train_dat, rep(vecs[i].pat));
      chk($sformatf("vec%0d_tx_en", i), tx_en, 1'b1);
      chk($sformatf("vec%0d_tx_dat", i), tx_dat, vecs[i].tx);
    end

    // STEP3 rotation with 3 patterns, stray 0x59 ignored.
    step();
    chk("rot1", train_dat, rep(8'hAA));
    rx_en = 1'b1;
    rx_dat = 8'h59;
    step();
    rx_en = 1'b0;
    rx_dat = 8'h00;
    chk("rot2", train_dat, rep(8'h99));
    chk("stray_ack_ignored", train_state, 4'd6);
    step();
    chk("rot_wrap", train_dat, rep(8'h55));
    step();
    chk("rot_wrap1", train_dat, rep(8'hAA));
    send(8'h5B);
    chk("end_state", train_state, 4'd7);
    chk("end_cycle", cyc, 72);
    step();
    chk("end_pat_zero", train_dat, '0);

    // END dwell: ticks fall on multiples of 10, boundary at 110 -> DONE at 111.
    cnt = 0;
    while (train_state !== 4'd8 && cnt < 60) begin
      step();
      cnt++;
    end
    chk("done_state", train_state, 4'd8);
    chk("done_cycle", cyc, 111);
    chk("done_flag_lag", train_done, 1'b0);
    step();
    chk("done_flag", train_done, 1'b1);
    chk("done_retry", retry_cnt, 8'd0);

    // RETRAIN from DONE.
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    chk("retrain_done_clr", train_done, 1'b0);
    chk("retrain_idle", train_state, 4'd0);
    wait_tx(80, n);
    chk("retrain_tx_seen", tx_en, 1'b1);
    chk("retrain_tx_delay", n, 42);
    chk("retrain_tx_dat", tx_dat, 8'h54);

    // Ack 0x58 then silence in STEP1: two retries, then ERROR.
    for (int i = 0; i < 3; i++) begin
      send(8'h58);
      chk($sformatf("to%0d_step1", i), train_state, 4'd4);
      cnt = 0;
      while (train_state === 4'd4 && cnt < 40) begin
        step();
        cnt++;
      end
      chk($sformatf("to%0d_window", i), (cnt >= 21 && cnt <= 30), 1'b1);
      if (i < 2) begin
        chk($sformatf("to%0d_state", i), train_state, 4'd2);
        chk($sformatf("to%0d_retry", i), retry_cnt, i + 1);
        wait_tx(5, n);
        chk($sformatf("to%0d_resend_delay", i), n, 1);
        chk($sformatf("to%0d_resend_dat", i), tx_dat, 8'h54);
      end else begin
        chk("err_state", train_state, 4'd9);
        chk("err_retry", retry_cnt, 8'd2);
        chk("err_flag_lag", train_err, 1'b0);
        step();
        chk("err_flag", train_err, 1'b1);
      end
    end

    // RETRAIN from ERROR.
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    chk("retrain_err_clr", train_err, 1'b0);
    chk("retrain_err_idle", train_state, 4'd0);
    step();
    chk("retry_cleared", retry_cnt, 8'd0);
    wait_tx(80, n);
    chk("err_retrain_tx_delay", n, 41);

    // No response: 0x54 resent every 40 cycles, only START/WAIT, no error.
    for (int r = 0; r < 2; r++) begin
      bad = 1'b0;
      cnt = 0;
      do begin
        step();
        cnt++;
        if (!(train_state === 4'd2 || train_state === 4'd3) || train_err !== 1'b0) bad = 1'b1;
      end while (tx_en !== 1'b1 && cnt < 60);
      chk($sformatf("resend%0d_interval", r), cnt, 40);
      chk($sformatf("resend%0d_dat", r), tx_dat, 8'h54);
      chk($sformatf("resend%0d_states", r), bad, 1'b0);
    end

    // Into STEP2, then synchronous reset.
    send(8'h58);
    wait_tx(5, n);
    chk("s2_reply_dat", tx_dat, 8'h55);
    send(8'h59);
    chk("s2_state", train_state, 4'd5);
    rst = 1'b1;
    step();
    chk("mid_rst_state", train_state, 4'd0);
    chk("mid_rst_tx_en", tx_en, 1'b0);
    chk("mid_rst_tx_dat", tx_dat, 8'h00);
    chk("mid_rst_train_dat", train_dat, '0);
    chk("mid_rst_done", train_done, 1'b0);
    chk("mid_rst_err", train_err, 1'b0);
    chk("mid_rst_retry", retry_cnt, 8'd0);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_init", train_state, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_train_master.md
# lvds_train_master

Parametrised LVDS link-training master for the IO serial side-channel. It drives the remote slave through the START/STEP1/STEP2/STEP3 handshake over an external UART byte stream, and presents training patterns on TRAIN_DAT for the LVDS serialiser. Compared with the first-generation trainer it adds:
- TX_RDY flow control
- per-step ack timeouts with bounded retry
- an error terminal state
- retrain on request
- a configurable step-3 pattern count

## Interface
- P_TICK, 20'hF4240: base tick period minus 1, in CLK cycles (5 ms at 200 MHz).
- P_PERIOD_TICKS, 40: ticks per long period (200 ms); used for init delay, start resend and END dwell.
- P_ACK_TICKS, 40: ticks allowed in STEP1/2/3 before timeout.
- P_RETRY_MAX, 8: timeouts tolerated before ERROR; range 1..255.
- P_PAT_NUM, 4: step-3 patterns rotated; range 1..4.
- C_DATA_WIDTH, 59: TRAIN_DAT width in bytes.
- CLK  in  1  sole clock.
- RST  in  1  synchronous, active-high reset.
- TX_RDY  in  1  UART can accept a byte this cycle.
- TX_EN  out  1  one-cycle byte strobe to UART.
- TX_DAT  out  8  byte to send; valid with TX_EN.
- RX_EN  in  1  received byte strobe.
- RX_DAT  in  8  received byte.
- RETRAIN  in  1  pulse; restarts training from DONE or ERROR.
- TRAIN_DAT  out  8*C_DATA_WIDTH  training pattern to serialiser.
- TRAIN_DONE  out  1  training complete, sticky until RETRAIN/RST.
- TRAIN_ERR  out  1  retries exhausted, sticky until RETRAIN/RST.
- TRAIN_STATE  out  4  current FSM state encoding.
- RETRY_CNT  out  8  timeouts since last IDLE.

## Operation
- FSM states: IDLE=0, INIT=1, START=2, WAIT=3, STEP1=4, STEP2=5, STEP3=6, END=7, DONE=8, ERROR=9. Any other encoding returns to IDLE.
- IDLE → INIT unconditionally.
- INIT → START at the first long-period boundary.
- START → WAIT after 1 cycle. START queues TX byte 0x54.
- WAIT:
  - → STEP1 on RX 0x58.
  - → START at the next long-period boundary (resend; not counted as a retry).
- STEP1 → STEP2 on RX 0x59. STEP2 → STEP3 on RX 0x5A. STEP3 → END on RX 0x5B.
- Each ack that advances the FSM queues a reply: 0x58 → 0x55, 0x59 → 0x56, 0x5A → 0x57. 0x5B queues nothing.
- RX bytes other than the ack expected in the current state are ignored.
- Step timeout:
  - The tick counter in STEP1/2/3 reloads on entry to each state.
  - Expiry while RETRY_CNT < P_RETRY_MAX: RETRY_CNT++, go to START.
  - Expiry otherwise: go to ERROR.
- END → DONE after one full long period. The period counter reloads while in STEP3.
- DONE and ERROR hold until RETRAIN; RETRAIN goes to IDLE. RETRAIN is ignored in other states.
- RETRY_CNT clears in IDLE.
- TRAIN_DAT is registered from the current state:
  - STEP1: 0x55 in every byte.
  - STEP2: 0x82 in every byte.
  - STEP3: rotates 0x55, 0xAA, 0x99, 0x66 (first P_PAT_NUM entries), one pattern per cycle. Rotation starts at index 0 on STEP3 entry and wraps after P_PAT_NUM-1.
  - All other states: 0.
- TX queue:
  - One-entry holding register with a pending flag.
  - TX_EN=1 and TX_DAT=held byte on any cycle where pending & TX_RDY; pending clears in that cycle.
  - A new request while pending overwrites the held byte (latest wins).

## Timing
- Reset values: TX_EN=0, TX_DAT=0, TRAIN_DAT=0, TRAIN_DONE=0, TRAIN_ERR=0, TRAIN_STATE=IDLE, RETRY_CNT=0, pending=0, tick counter=P_TICK, period counter=P_PERIOD_TICKS.
- Reset asserted mid-operation forces all of these on the next edge.
- Tick counter runs in every state except IDLE.
- Reply latency: RX_EN on cycle n → state changes at n+1 → TX_EN at n+2 earliest, when TX_RDY=1 at n+2.
- START: TX_EN of 0x54 at START-entry+1 earliest.
- TRAIN_DAT lags TRAIN_STATE by 1 cycle.
- TRAIN_DONE/TRAIN_ERR rise 1 cycle after entering DONE/ERROR. Both clear 1 cycle after RETRAIN is accepted.
- Ack and timeout in the same cycle: ack wins, no retry counted.
- Queue request and drain in the same cycle: the new byte is held and pending stays 1.

## Structure
- Package lvds_train_pkg holds:
  - state localparams
  - TX codes 0x54–0x57 and RX ack codes 0x58–0x5B
  - the four pattern bytes
  - the ack-to-state mapping function
- Sub-module lvds_train_tick: P_TICK prescaler plus loadable period/timeout counter. Outputs tick and period-boundary strobes; inputs run and reload.
- Top holds the FSM, TX queue, pattern generator and retry counter. Target size ~250 lines.

## Test plan
All scenarios use P_TICK=9, P_PERIOD_TICKS=4, P_ACK_TICKS=3.
- Happy path, TX_RDY=1. After reset, respond to each TX byte with the next ack → TX sequence 0x54, 0x55, 0x56, 0x57; TRAIN_DONE=1 one long period after 0x5B; RETRY_CNT=0.
- No 0x58 response → 0x54 resent every 40 cycles; FSM never leaves START/WAIT; TRAIN_ERR stays 0.
- Ack 0x58 then silence, P_RETRY_MAX=2 → two timeouts return to START with RETRY_CNT=1 then 2; third timeout gives TRAIN_STATE=9 and TRAIN_ERR=1.
- TX_RDY held 0 for 20 cycles while 0x54 is queued → no TX_EN; TX_EN with 0x54 on the first cycle TX_RDY=1.
- In STEP3 with P_PAT_NUM=3 → TRAIN_DAT bytes cycle 0x55, 0xAA, 0x99, 0x55…; out-of-order RX 0x59 is ignored.
- RETRAIN in DONE → TRAIN_DONE=0 next cycle, back to IDLE, 0x54 resent after the init period. RST asserted in STEP2 → all outputs at reset values next cycle.
